// File: rtl/cla_nibble_sequencer_if.sv
// Request/result bundle between a requesting datapath and cla_nibble_sequencer.
// The optional subtract control (sub) exists only when CLA_SEQ_SUB_EN is defined.
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef CLA_SEQ_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice is stepped over the
// latched operands one nibble per clock, LSB nibble first, with a registered
// carry between nibbles. Optional subtract mode under macro CLA_SEQ_SUB_EN.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [3:0]         p, g, nib_sum;
  logic [4:0]         c;

  // Shared 4-bit CLA slice on the nibble currently selected by idx.
  always_comb begin
    p = a_q[{idx_q, 2'b00} +: 4] ^ b_q[{idx_q, 2'b00} +: 4];
    g = a_q[{idx_q, 2'b00} +: 4] & b_q[{idx_q, 2'b00} +: 4];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry_q);
    nib_sum = p ^ c[3:0];
  end

  // Next-state and datapath update: latch on start, step nibbles in RUN, pulse in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          idx_d   = '0;
`ifdef CLA_SEQ_SUB_EN
          // Subtract as a + ~b + 1; carry-in is forced and cin is ignored.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
        carry_d = c[4];
        if (idx_q == LAST_IDX) begin
          cout_d  = c[4];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any add in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
